// File: rtl/wgt_buf_pp.sv
// wgt_buf_pp: ping-pong weight buffer feeding the PE array.
//
// Packed weight words arrive over a valid/ready stream and are unpacked,
// MSB lane first, into a shadow bank. A read request moves a complete
// shadow tile into the output bank. The next tile can then be loaded while
// the PE array consumes the current one.
//
// Optional feature macro: WGT_BUF_ERR_EN adds the sticky underflow flag wgt_err.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   wgt_in_valid input word valid
//   wgt_in_ready buffer accepts a word this cycle (0 while rst is high)
//   wgt_in_data  packed weight word, IN_WIDTH bits
//   wgt_clear    discard the partially or fully loaded shadow tile
//   wgt_read     request transfer of the shadow tile to the output bank
//   wgt_output   signed weights to the PEs, PE_ARR_SIZE x WGT_WIDTH
//   wgt_valid    wgt_output holds a loaded tile
//   wgt_stall    one-cycle pulse: read requested with no complete shadow tile
//   wgt_err      sticky underflow flag (WGT_BUF_ERR_EN only)
module wgt_buf_pp #(
   parameter int WGT_WIDTH   = 8,
   parameter int IN_WIDTH    = 32,
   parameter int PE_ARR_SIZE = 9
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wgt_in_valid,
   output logic                        wgt_in_ready,
   input  logic [IN_WIDTH-1:0]         wgt_in_data,
   input  logic                        wgt_clear,
   input  logic                        wgt_read,
   output logic signed [WGT_WIDTH-1:0] wgt_output [PE_ARR_SIZE],
   output logic                        wgt_valid,
   output logic                        wgt_stall
`ifdef WGT_BUF_ERR_EN
   ,
   output logic                        wgt_err
`endif
);

   localparam int PACK  = IN_WIDTH / WGT_WIDTH;
   localparam int WORDS = (PE_ARR_SIZE + PACK - 1) / PACK;
   localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic {
      S_LOAD,
      S_FULL
   } state_t;

   state_t                      state;
   logic [CNT_W-1:0]            word_cnt;
   logic signed [WGT_WIDTH-1:0] shadow [PE_ARR_SIZE];
   logic                        handshake;
   logic                        last_word;

   assign wgt_in_ready = (state == S_LOAD) && !rst;
   assign handshake    = wgt_in_valid && wgt_in_ready;
   assign last_word    = (word_cnt == CNT_W'(WORDS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_LOAD;
         word_cnt  <= '0;
         wgt_valid <= 1'b0;
         wgt_stall <= 1'b0;
`ifdef WGT_BUF_ERR_EN
         wgt_err   <= 1'b0;
`endif
         for (int unsigned e = 0; e < PE_ARR_SIZE; e++) begin
            shadow[e]     <= '0;
            wgt_output[e] <= '0;
         end
      end else begin
         wgt_stall <= 1'b0;
         if (wgt_clear) begin
            // Clear wins over read and over any coincident handshake.
            state    <= S_LOAD;
            word_cnt <= '0;
         end else if (state == S_FULL) begin
            if (wgt_read) begin
               for (int unsigned e = 0; e < PE_ARR_SIZE; e++)
                  wgt_output[e] <= shadow[e];
               wgt_valid <= 1'b1;
               state     <= S_LOAD;
            end
         end else begin
            // Read while loading is an underflow; the word stream is still
            // accepted, so a coincident last word completes the tile.
            if (wgt_read) begin
               wgt_stall <= 1'b1;
`ifdef WGT_BUF_ERR_EN
               wgt_err   <= 1'b1;
`endif
            end
            if (handshake) begin
               // Element e lives in word e/PACK, lane e%PACK (MSB lane first);
               // lanes past PE_ARR_SIZE in the last word have no element.
               for (int unsigned e = 0; e < PE_ARR_SIZE; e++) begin
                  if (CNT_W'(e / PACK) == word_cnt)
                     shadow[e] <= wgt_in_data[IN_WIDTH-1-(e%PACK)*WGT_WIDTH -: WGT_WIDTH];
               end
               if (last_word) begin
                  word_cnt <= '0;
                  state    <= S_FULL;
               end else begin
                  word_cnt <= word_cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_wgt_buf_pp.sv
// tb_wgt_buf_pp: directed, table-driven bench for wgt_buf_pp with the default
// geometry, plus a second instance with 64-bit words and 16-bit weights.
module tb_wgt_buf_pp;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid, ready, clr, rd, ovalid, stall;
   logic [31:0] data;
   logic signed [7:0] out [9];
`ifdef WGT_BUF_ERR_EN
   logic        err;
   logic        exp_err;
`endif

   logic        valid2, ready2, clr2, rd2, ovalid2, stall2;
   logic [63:0] data2;
   logic signed [15:0] out2 [9];
`ifdef WGT_BUF_ERR_EN
   logic        err2;
`endif

   logic [71:0]  flat;
   logic [143:0] flat2;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   wgt_buf_pp dut (
      .clk(clk), .rst(rst), .wgt_in_valid(valid), .wgt_in_ready(ready),
      .wgt_in_data(data), .wgt_clear(clr), .wgt_read(rd),
      .wgt_output(out), .wgt_valid(ovalid), .wgt_stall(stall)
`ifdef WGT_BUF_ERR_EN
      , .wgt_err(err)
`endif
   );

   wgt_buf_pp #(.WGT_WIDTH(16), .IN_WIDTH(64), .PE_ARR_SIZE(9)) dut2 (
      .clk(clk), .rst(rst), .wgt_in_valid(valid2), .wgt_in_ready(ready2),
      .wgt_in_data(data2), .wgt_clear(clr2), .wgt_read(rd2),
      .wgt_output(out2), .wgt_valid(ovalid2), .wgt_stall(stall2)
`ifdef WGT_BUF_ERR_EN
      , .wgt_err(err2)
`endif
   );

   // Element 0 in the most significant byte, matching the hex tile constants.
   always_comb begin
      flat  = '0;
      flat2 = '0;
      for (int i = 0; i < 9; i++) begin
         flat[(8-i)*8 +: 8]    = out[i];
         flat2[(8-i)*16 +: 16] = out2[i];
      end
   end

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        c;
      logic        r;
      logic        e_rdy;
      logic        e_vld;
      logic        e_stall;
      logic [71:0] e_out;
   } vec_t;

   vec_t tbl [30];

   function automatic vec_t mk(input logic v, input logic [31:0] d,
                               input logic c, input logic r,
                               input logic e_rdy, input logic e_vld,
                               input logic e_stall, input logic [71:0] e_out);
      vec_t t;
      t.v = v; t.d = d; t.c = c; t.r = r;
      t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_stall = e_stall; t.e_out = e_out;
      return t;
   endfunction

   task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic c, input logic r);
      valid = v; data = d; clr = c; rd = r;
   endtask

   localparam logic [71:0] Z = 72'h0;
   localparam logic [71:0] A = 72'h010203040506070809;
   localparam logic [71:0] B = 72'h111111111111111111;
   localparam logic [71:0] C = 72'hFF807F007F7F7F7F80;
   localparam logic [71:0] D = 72'h0A0B0C0D0E0F101112;
   localparam logic [71:0] E = 72'h444444444444444444;

   initial begin
      // Load 1..9 with dropped lanes, ignored word in FULL, read.
      tbl[0]  = mk(1, 32'h01020304, 0, 0, 1, 0, 0, Z);
      tbl[1]  = mk(1, 32'h05060708, 0, 0, 1, 0, 0, Z);
      tbl[2]  = mk(1, 32'h09AABBCC, 0, 0, 0, 0, 0, Z);
      tbl[3]  = mk(1, 32'hDEADBEEF, 0, 0, 0, 0, 0, Z);
      tbl[4]  = mk(0, 32'h0,        0, 1, 1, 1, 0, A);
      // Overlapped load of 0x11 tile with an underflow read in the middle.
      tbl[5]  = mk(1, 32'h11111111, 0, 0, 1, 1, 0, A);
      tbl[6]  = mk(1, 32'h11111111, 0, 1, 1, 1, 1, A);
      tbl[7]  = mk(1, 32'h11111111, 0, 0, 0, 1, 0, A);
      tbl[8]  = mk(0, 32'h0,        0, 1, 1, 1, 0, B);
      // Signed tile; last word coincident with read counts as underflow.
      tbl[9]  = mk(1, 32'hFF807F00, 0, 0, 1, 1, 0, B);
      tbl[10] = mk(1, 32'h7F7F7F7F, 0, 0, 1, 1, 0, B);
      tbl[11] = mk(1, 32'h80000000, 0, 1, 0, 1, 1, B);
      tbl[12] = mk(0, 32'h0,        0, 1, 1, 1, 0, C);
      // Clear after two words; the coincident word is discarded.
      tbl[13] = mk(1, 32'h01010101, 0, 0, 1, 1, 0, C);
      tbl[14] = mk(1, 32'h02020202, 0, 0, 1, 1, 0, C);
      tbl[15] = mk(1, 32'h03030303, 1, 0, 1, 1, 0, C);
      tbl[16] = mk(1, 32'h0A0B0C0D, 0, 0, 1, 1, 0, C);
      tbl[17] = mk(1, 32'h0E0F1011, 0, 0, 1, 1, 0, C);
      tbl[18] = mk(1, 32'h12000000, 0, 0, 0, 1, 0, C);
      tbl[19] = mk(0, 32'h0,        0, 1, 1, 1, 0, D);
      // Full tile, then clear+read: no transfer, no stall.
      tbl[20] = mk(1, 32'h33333333, 0, 0, 1, 1, 0, D);
      tbl[21] = mk(1, 32'h33333333, 0, 0, 1, 1, 0, D);
      tbl[22] = mk(1, 32'h33333333, 0, 0, 0, 1, 0, D);
      tbl[23] = mk(0, 32'h0,        1, 1, 1, 1, 0, D);
      tbl[24] = mk(0, 32'h0,        0, 1, 1, 1, 1, D);
      tbl[25] = mk(0, 32'h0,        0, 0, 1, 1, 0, D);
      tbl[26] = mk(1, 32'h44444444, 0, 0, 1, 1, 0, D);
      tbl[27] = mk(1, 32'h44444444, 0, 0, 1, 1, 0, D);
      tbl[28] = mk(1, 32'h44444444, 0, 0, 0, 1, 0, D);
      tbl[29] = mk(0, 32'h0,        0, 1, 1, 1, 0, E);

      rst = 1'b1;
      drive(0, 32'h0, 0, 0);
      valid2 = 1'b0; data2 = '0; clr2 = 1'b0; rd2 = 1'b0;
`ifdef WGT_BUF_ERR_EN
      exp_err = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", 144'(ready), 144'(0));
      chk("reset_valid", 144'(ovalid), 144'(0));
      chk("reset_stall", 144'(stall), 144'(0));
      chk("reset_out", 144'(flat), 144'(Z));
`ifdef WGT_BUF_ERR_EN
      chk("reset_err", 144'(err), 144'(0));
`endif
      rst = 1'b0;

      for (int i = 0; i < 30; i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].r);
         @(posedge clk);
         #1;
         chk($sformatf("row%0d_ready", i), 144'(ready),  144'(tbl[i].e_rdy));
         chk($sformatf("row%0d_valid", i), 144'(ovalid), 144'(tbl[i].e_vld));
         chk($sformatf("row%0d_stall", i), 144'(stall),  144'(tbl[i].e_stall));
         chk($sformatf("row%0d_out", i),   144'(flat),   144'(tbl[i].e_out));
`ifdef WGT_BUF_ERR_EN
         if (tbl[i].e_stall) exp_err = 1'b1;
         chk($sformatf("row%0d_err", i), 144'(err), 144'(exp_err));
`endif
         if (i == 12) begin
            chk("signed_e0", 144'(int'(out[0]) + 1000), 144'(999));
            chk("signed_e1", 144'(int'(out[1]) + 1000), 144'(872));
            chk("signed_e2", 144'(int'(out[2]) + 1000), 144'(1127));
            chk("signed_e3", 144'(int'(out[3]) + 1000), 144'(1000));
         end
      end
      drive(0, 32'h0, 0, 0);

      // Reset mid-load: partial tile dropped, outputs and valid cleared.
      drive(1, 32'h55555555, 0, 0);
      repeat (2) @(posedge clk);
      rst = 1'b1;
      drive(0, 32'h0, 0, 0);
      @(posedge clk);
      #1;
      chk("rstmid_ready", 144'(ready), 144'(0));
      chk("rstmid_out", 144'(flat), 144'(Z));
      chk("rstmid_valid", 144'(ovalid), 144'(0));
`ifdef WGT_BUF_ERR_EN
      exp_err = 1'b0;
      chk("rstmid_err", 144'(err), 144'(0));
`endif
      rst = 1'b0;
      drive(1, 32'h01020304, 0, 0);
      @(posedge clk); #1;
      chk("rstmid_w1_ready", 144'(ready), 144'(1));
      drive(1, 32'h05060708, 0, 0);
      @(posedge clk); #1;
      chk("rstmid_w2_ready", 144'(ready), 144'(1));
      drive(1, 32'h09000000, 0, 0);
      @(posedge clk); #1;
      chk("rstmid_w3_ready", 144'(ready), 144'(0));
      drive(0, 32'h0, 0, 1);
      @(posedge clk); #1;
      chk("rstmid_read_out", 144'(flat), 144'(A));
      chk("rstmid_read_valid", 144'(ovalid), 144'(1));
      drive(0, 32'h0, 0, 0);

      // 64-bit words, 16-bit weights: 4 lanes, last word keeps lane 0 only.
      valid2 = 1'b1; data2 = 64'h0001_0002_0003_0004;
      @(posedge clk); #1;
      chk("wide_w1_ready", 144'(ready2), 144'(1));
      data2 = 64'h0005_0006_0007_0008;
      @(posedge clk); #1;
      chk("wide_w2_ready", 144'(ready2), 144'(1));
      data2 = 64'h0009_AAAA_BBBB_CCCC;
      @(posedge clk); #1;
      chk("wide_w3_ready", 144'(ready2), 144'(0));
      chk("wide_pre_read_out", flat2, 144'h0);
      valid2 = 1'b0; rd2 = 1'b1;
      @(posedge clk); #1;
      chk("wide_out", flat2, 144'h0001_0002_0003_0004_0005_0006_0007_0008_0009);
      chk("wide_valid", 144'(ovalid2), 144'(1));
      chk("wide_signed_e8", 144'(int'(out2[8])), 144'(9));
      rd2 = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/wgt_buf_pp.md
Name: wgt_buf_pp

Overview:
- Double-buffered (ping-pong) weight buffer feeding the PE array.
- Accepts packed weight words over a valid/ready stream and unpacks them into a shadow bank, while the PE array consumes a stable output bank.
- On a read request, the completed shadow bank is transferred to the output bank. Loading of the next kernel tile then overlaps with compute on the current one.
- Generalises the fixed 32-bit/8-bit/9-PE weight buffer to arbitrary widths and array size, and adds flow control, completion tracking and underflow reporting.

Parameters:
- WGT_WIDTH, 8: bits per signed weight.
- IN_WIDTH, 32: bits per input word. Must be a multiple of WGT_WIDTH and ≥ WGT_WIDTH.
- PE_ARR_SIZE, 9: number of weights per tile (one per PE).
- Derived localparams, not overridable:
  - PACK = IN_WIDTH/WGT_WIDTH.
  - WORDS = ceil(PE_ARR_SIZE/PACK).
  - CNT_W = max(1, clog2(WORDS)).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- wgt_in_valid  in  1  input word valid.
- wgt_in_ready  out  1  buffer can accept a word this cycle.
- wgt_in_data  in  IN_WIDTH  packed weight word.
- wgt_clear  in  1  discard partially/fully loaded shadow tile.
- wgt_read  in  1  request transfer of shadow tile to output.
- wgt_output  out  signed WGT_WIDTH x PE_ARR_SIZE (unpacked array)  weights to PEs.
- wgt_valid  out  1  wgt_output holds a loaded tile.
- wgt_stall  out  1  one-cycle pulse: wgt_read arrived with no complete shadow tile.
- wgt_err  out  1  sticky underflow flag; exists only with WGT_BUF_ERR_EN.

Behaviour:
- Reset (rst=1 at posedge):
  - state=S_LOAD, word_cnt=0, shadow bank=0.
  - wgt_output all 0, wgt_valid=0, wgt_stall=0, wgt_err=0.
  - wgt_in_ready is forced 0 while rst=1.
  - Reset mid-load discards the partial tile.
- State machine, 2 states:
  - S_LOAD:
    - wgt_in_ready=1.
    - A handshake (valid & ready) writes word w=word_cnt into the shadow bank.
    - Lane k (k=0..PACK-1) goes to element w*PACK+k, taken from bits [IN_WIDTH-1-k*WGT_WIDTH -: WGT_WIDTH], i.e. MSB lane first.
    - Elements with index ≥ PE_ARR_SIZE are dropped.
    - word_cnt increments. On a handshake with word_cnt==WORDS-1: word_cnt→0, go to S_FULL.
  - S_FULL:
    - wgt_in_ready=0; valid is ignored.
    - On wgt_read: wgt_output ← shadow bank at the next edge, wgt_valid→1, go to S_LOAD.
- Latency:
  - wgt_output changes the cycle after wgt_read is sampled in S_FULL.
  - The first new word can be accepted on that same following cycle.
- wgt_output holds its value in every cycle without a successful transfer (including during loading and stall).
- wgt_read in S_LOAD (underflow):
  - No transfer; wgt_output and wgt_valid unchanged.
  - wgt_stall=1 for exactly the next cycle.
- Simultaneous last-word handshake and wgt_read in S_LOAD: treated as underflow (stall pulse). The tile becomes readable from the next cycle.
- wgt_clear (any state): next cycle state=S_LOAD, word_cnt=0; wgt_output and wgt_valid untouched.
  - Priority: rst > wgt_clear > wgt_read > input handshake.
  - A handshake coincident with clear is discarded.
  - wgt_read coincident with clear: no transfer, no stall.
- wgt_valid only returns to 0 on reset.
- Shadow bank elements not rewritten keep prior values. Every element is rewritten each tile by construction.

Optional Feature:
- Macro WGT_BUF_ERR_EN.
- Defined:
  - Port wgt_err exists.
  - It is set on the cycle wgt_stall pulses, stays set until rst, and is unaffected by wgt_clear.
- Undefined:
  - Port wgt_err and its register are absent.
  - wgt_stall is unchanged.

Test Plan:
- Defaults. Reset, then send 0x01020304, 0x05060708, 0x09AABBCC. wgt_in_ready drops after the 3rd handshake. wgt_read → next cycle wgt_output=1..9, wgt_valid=1 (0xAA/0xBB/0xCC dropped).
- Signed: tile whose first word is 0xFF807F00 → elements 0..3 = -1, -128, 127, 0.
- Overlap: after a transfer, load a second tile (all 0x11). wgt_output stays 1..9 throughout loading; it becomes 0x11 only the cycle after the second wgt_read.
- Underflow: wgt_read after 1 of 3 words → wgt_stall 1-cycle pulse, output unchanged; wgt_err=1 and remains 1 (ERR_EN). Finishing the tile then allows a normal read.
- Clear/reset: after 2 words, assert wgt_clear → word_cnt=0. The next 3 words form a new tile, and reading yields those values. Repeat with rst mid-load → outputs 0, wgt_valid=0.
- Parameter sweep IN_WIDTH=64, WGT_WIDTH=16, PE_ARR_SIZE=9 → WORDS=3, correct MSB-first unpacking, last-word lanes 1..3 dropped.
